fwd_hazard_ctrl: RTL and testbench

//  Decode-stage forwarding/hazard controller; sits directly upstream of RB_Block.

---
 rtl/fwd_hazard_ctrl_pkg.sv | 23 ++
 rtl/fwd_hazard_ctrl_if.sv | 33 +++
 rtl/fwd_hazard_ctrl_fwd_sel.sv | 22 ++
 rtl/fwd_hazard_ctrl.sv | 73 +++++++
 tb/tb_fwd_hazard_ctrl.sv | 133 +++++++++++++
 5 files changed

// File: rtl/fwd_hazard_ctrl_pkg.sv
// rtl/fwd_hazard_ctrl_pkg.sv - shared encodings, stage entry type and match helper
package fwd_hazard_ctrl_pkg;

  localparam int STAGE_AW = 5;

  localparam logic [1:0] SEL_BANK = 2'b00;
  localparam logic [1:0] SEL_EX   = 2'b01;
  localparam logic [1:0] SEL_DM   = 2'b10;
  localparam logic [1:0] SEL_WB   = 2'b11;

  typedef struct packed {
    logic                v;
    logic                we;
    logic                ld;
    logic [STAGE_AW-1:0] rw;
  } stage_t;

  // R0 is hardwired zero, so a write to it is never a forwarding source.
  function automatic logic live_match(stage_t s, logic [STAGE_AW-1:0] r);
    return s.v & s.we & (s.rw == r) & (r != '0);
  endfunction

endpackage

// File: rtl/fwd_hazard_ctrl_if.sv
// rtl/fwd_hazard_ctrl_if.sv - decode-side bundle between decoder and hazard controller
interface fwd_hazard_ctrl_if #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
);
  logic              id_valid;
  logic [REG_AW-1:0] RA;
  logic [REG_AW-1:0] RB;
  logic [REG_AW-1:0] RW;
  logic              rw_en;
  logic              is_load;
  logic              use_imm;
  logic              flush;
  logic [1:0]        mux_sel_A;
  logic [1:0]        mux_sel_B;
  logic              imm_sel;
  logic              stall;
  logic [REG_AW-1:0] RW_ex;
  logic [REG_AW-1:0] RW_dm;
  logic [REG_AW-1:0] RW_wb;
  logic              we_dm;
  logic [CNT_W-1:0]  stall_cnt;

  modport master (
    output id_valid, RA, RB, RW, rw_en, is_load, use_imm, flush,
    input  mux_sel_A, mux_sel_B, imm_sel, stall, RW_ex, RW_dm, RW_wb, we_dm, stall_cnt
  );

  modport slave (
    input  id_valid, RA, RB, RW, rw_en, is_load, use_imm, flush,
    output mux_sel_A, mux_sel_B, imm_sel, stall, RW_ex, RW_dm, RW_wb, we_dm, stall_cnt
  );
endinterface

// File: rtl/fwd_hazard_ctrl_fwd_sel.sv
// rtl/fwd_hazard_ctrl_fwd_sel.sv - priority operand-source select, youngest producer wins
module fwd_sel
  import fwd_hazard_ctrl_pkg::*;
(
  input  logic [STAGE_AW-1:0] src,
  input  logic                en,
  input  stage_t              ex,
  input  stage_t              dm,
  input  stage_t              wb,
  output logic [1:0]          sel
);

  always_comb begin
    sel = SEL_BANK;
    if (en) begin
      if (live_match(ex, src))      sel = SEL_EX;
      else if (live_match(dm, src)) sel = SEL_DM;
      else if (live_match(wb, src)) sel = SEL_WB;
    end
  end

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// rtl/fwd_hazard_ctrl.sv - decode-stage forwarding and load-use hazard controller
module fwd_hazard_ctrl
  import fwd_hazard_ctrl_pkg::*;
#(
  parameter int REG_AW = STAGE_AW,
  parameter int CNT_W  = 16
) (
  input logic              clk,
  input logic              rst,
  fwd_hazard_ctrl_if.slave bus
);

  stage_t           ex_q, dm_q, wb_q, ex_d;
  logic             ld_hit;
  logic             stall;
  logic [CNT_W-1:0] cnt_q;

  fwd_sel u_sel_a (
    .src (bus.RA),
    .en  (1'b1),
    .ex  (ex_q),
    .dm  (dm_q),
    .wb  (wb_q),
    .sel (bus.mux_sel_A)
  );

  fwd_sel u_sel_b (
    .src (bus.RB),
    .en  (~bus.use_imm),
    .ex  (ex_q),
    .dm  (dm_q),
    .wb  (wb_q),
    .sel (bus.mux_sel_B)
  );

  // A load in EX has no result yet; only DM onward can forward it.
  assign ld_hit = ex_q.ld & (live_match(ex_q, bus.RA) |
                             (live_match(ex_q, bus.RB) & ~bus.use_imm));
  assign stall  = bus.id_valid & ~bus.flush & ld_hit;

  always_comb begin
    ex_d = '0;
    if (bus.id_valid & ~bus.flush & ~stall) begin
      ex_d.v  = 1'b1;
      ex_d.we = bus.rw_en;
      ex_d.ld = bus.is_load;
      ex_d.rw = bus.RW;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q  <= '0;
      dm_q  <= '0;
      wb_q  <= '0;
      cnt_q <= '0;
    end else begin
      ex_q <= ex_d;
      dm_q <= ex_q;
      wb_q <= dm_q;
      if (stall && (cnt_q != {CNT_W{1'b1}})) cnt_q <= cnt_q + 1'b1;
    end
  end

  assign bus.imm_sel   = bus.use_imm;
  assign bus.stall     = stall;
  assign bus.RW_ex     = ex_q.rw;
  assign bus.RW_dm     = dm_q.v ? dm_q.rw : '0;
  assign bus.RW_wb     = wb_q.rw;
  assign bus.we_dm     = dm_q.v & dm_q.we;
  assign bus.stall_cnt = cnt_q;

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// tb/tb_fwd_hazard_ctrl.sv - scoreboard bench for fwd_hazard_ctrl with directed vectors
module tb_fwd_hazard_ctrl;

  localparam int REG_AW = 5;
  localparam int CNT_W  = 16;

  typedef struct {
    int          id;
    logic [1:0]  sel_a;
    logic [1:0]  sel_b;
    logic        imm;
    logic        stall;
    logic        we_dm;
    logic [4:0]  rw_dm;
    logic [15:0] cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  exp_t exp_q[$];
  int   n_vec  = 0;
  int   n_fail = 0;
  int   vid    = 0;

  fwd_hazard_ctrl_if #(.REG_AW(REG_AW), .CNT_W(CNT_W)) bus ();

  fwd_hazard_ctrl #(.REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic vec(input logic r, input logic v, input logic [4:0] ra, input logic [4:0] rb,
                     input logic [4:0] rw, input logic wen, input logic ld, input logic imm,
                     input logic fl, input logic [1:0] ea, input logic [1:0] eb, input logic est,
                     input logic ewe, input logic [4:0] erw, input logic [15:0] ecnt);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r;
    bus.id_valid = v;
    bus.RA = ra;
    bus.RB = rb;
    bus.RW = rw;
    bus.rw_en = wen;
    bus.is_load = ld;
    bus.use_imm = imm;
    bus.flush = fl;
    vid++;
    e.id = vid;
    e.sel_a = ea;
    e.sel_b = eb;
    e.imm = imm;
    e.stall = est;
    e.we_dm = ewe;
    e.rw_dm = erw;
    e.cnt = ecnt;
    exp_q.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_vec++;
        if (bus.mux_sel_A !== e.sel_a || bus.mux_sel_B !== e.sel_b || bus.imm_sel !== e.imm ||
            bus.stall !== e.stall || bus.we_dm !== e.we_dm || bus.RW_dm !== e.rw_dm ||
            bus.stall_cnt !== e.cnt) begin
          n_fail++;
          $display("FAIL vec%0d: got a=%b b=%b imm=%b stall=%b we_dm=%b rw_dm=%0d cnt=%0d, want a=%b b=%b imm=%b stall=%b we_dm=%b rw_dm=%0d cnt=%0d",
                   e.id, bus.mux_sel_A, bus.mux_sel_B, bus.imm_sel, bus.stall, bus.we_dm,
                   bus.RW_dm, bus.stall_cnt, e.sel_a, e.sel_b, e.imm, e.stall, e.we_dm,
                   e.rw_dm, e.cnt);
        end
      end
    end
  end

  initial begin : driver
    int guard;
    bus.id_valid = 1'b0;
    bus.RA = '0;
    bus.RB = '0;
    bus.RW = '0;
    bus.rw_en = 1'b0;
    bus.is_load = 1'b0;
    bus.use_imm = 1'b0;
    bus.flush = 1'b0;
    repeat (2) @(posedge clk);
    //  rst v  RA RB RW wen ld imm fl | a      b      st we rw cnt
    vec(0, 0, 3, 4, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0);  // reset state
    vec(0, 1, 1, 2, 3, 1, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0);  // add r3
    vec(0, 1, 3, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 0, 0, 0, 0);  // r3 from EX
    vec(0, 1, 1, 3, 0, 0, 0, 0, 0, 2'b00, 2'b10, 0, 1, 3, 0);  // r3 from DM
    vec(0, 1, 3, 1, 0, 0, 0, 0, 0, 2'b11, 2'b00, 0, 0, 0, 0);  // r3 from WB
    vec(0, 1, 3, 3, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0);  // r3 from bank
    vec(0, 1, 0, 0, 5, 1, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0);  // r5 write #1
    vec(0, 1, 0, 0, 5, 1, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0);  // r5 write #2
    vec(0, 1, 5, 5, 0, 0, 0, 0, 0, 2'b01, 2'b01, 0, 1, 5, 0);  // EX beats DM
    vec(0, 1, 0, 0, 7, 1, 1, 0, 0, 2'b00, 2'b00, 0, 1, 5, 0);  // load r7
    vec(0, 1, 7, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 1, 0, 0, 0);  // load-use stall
    vec(0, 1, 7, 0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 0, 1, 7, 1);  // replay from DM
    vec(0, 1, 7, 7, 0, 0, 0, 0, 0, 2'b11, 2'b11, 0, 0, 0, 1);  // second dependent, no stall
    vec(0, 1, 0, 0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 1);  // write r0
    vec(0, 1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 1);  // r0 never forwarded
    vec(0, 1, 0, 0, 9, 1, 1, 0, 0, 2'b00, 2'b00, 0, 1, 0, 1);  // load r9
    vec(0, 1, 1, 9, 0, 0, 0, 1, 0, 2'b00, 2'b00, 0, 0, 0, 1);  // imm hides RB hazard
    vec(0, 1, 0, 0, 2, 1, 1, 0, 0, 2'b00, 2'b00, 0, 1, 9, 1);  // load r2
    vec(0, 1, 2, 0, 4, 1, 0, 0, 1, 2'b01, 2'b00, 0, 0, 0, 1);  // flush beats stall
    vec(0, 0, 2, 0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 0, 1, 2, 1);  // load r2 reaches DM
    vec(0, 0, 4, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 1);  // flushed r4 never entered
    vec(0, 1, 0, 0, 6, 1, 1, 0, 0, 2'b00, 2'b00, 0, 0, 0, 1);  // load r6
    vec(1, 1, 6, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 1, 0, 0, 1);  // rst during stall
    vec(0, 1, 6, 6, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0);  // pipeline empty after rst
    guard = 0;
    while (exp_q.size() > 0 && guard < 20) begin
      @(posedge clk);
      guard++;
    end
    if (exp_q.size() > 0) begin
      n_vec++;
      n_fail++;
      $display("FAIL drain: %0d expected entries left, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
